// File: rtl/prime_deint_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prime_deint_pkg
//  Description : Shared helpers for the prime-step deinterleaver: address
//                width calculation, coprimality check and modulo address step.
//  Revision    : 1.0 - initial release
// ============================================================================
package prime_deint_pkg;

    // Address width for a buffer of len entries, never narrower than one bit.
    function automatic int unsigned calc_aw(input int unsigned len);
        return (len <= 1) ? 1 : $clog2(len);
    endfunction

    // Euclid's algorithm; used only at elaboration to validate P against N.
    function automatic bit is_coprime(input int unsigned p, input int unsigned n);
        int unsigned a;
        int unsigned b;
        int unsigned t;
        a = p;
        b = n;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return (a == 1);
    endfunction

    // (addr + p) mod n for addr < n and p < n: a single conditional subtract,
    // so no multiplier or divider is ever inferred.
    function automatic logic [31:0] addr_step(input logic [31:0] addr,
                                              input logic [31:0] p,
                                              input logic [31:0] n);
        logic [31:0] sum;
        sum = addr + p;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prime_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : prime_addr_gen
//  Description : Prime-step address sequence generator, producing
//                (P*k) mod N for successive advance pulses. Used on the write
//                side of the deinterleaver and on the read side of an
//                interleaver.
//  Revision    : 1.0 - initial release
// ============================================================================
module prime_addr_gen
    import prime_deint_pkg::*;
#(
    parameter int N  = 10,
    parameter int P  = 3,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] r_addr;

    // Address register: clear wins over advance so a frame boundary always
    // restarts the sequence at zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_addr <= '0;
        end else if (advance) begin
            r_addr <= AW'(addr_step(32'({1'b0, r_addr}), 32'(P), 32'(N)));
        end
    end

    assign addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/prime_deinterleaver_stream.sv
`default_nettype none
// ============================================================================
//  Module      : prime_deinterleaver_stream
//  Description : Streaming inverse prime-step permutation with a ping-pong
//                buffer: out[(P*i) % N] = in[i] for i < N, tail symbols pass
//                through in place. One bank fills while the other drains.
//  Revision    : 1.0 - initial release
// ============================================================================
module prime_deinterleaver_stream
    import prime_deint_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int N         = 10,
    parameter int P         = 3,
    parameter int TAIL_BITS = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_data,
    input  logic            in_last,
    output logic            in_frame_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_data,
    output logic            out_last
);

    localparam int            L       = N + TAIL_BITS;
    localparam int            AW      = int'(calc_aw(L));
    localparam logic [AW:0]   c_N_EXT = (AW + 1)'(N);
    localparam logic [AW-1:0] c_LAST  = AW'(L - 1);

    // Parameter sanity: a non-coprime step would not be a permutation.
    generate
        if (N < 2 || P <= 0 || P >= N || !is_coprime(P, N)) begin : g_bad_params
            $error("prime_deinterleaver_stream: need N >= 2, 0 < P < N, gcd(P, N) = 1");
        end
    endgenerate

    // Storage and control state
    logic [BITS-1:0] r_mem [0:1][0:L-1];
    logic [1:0]      r_full;
    logic            r_wbank;
    logic            r_rbank;
    logic [AW-1:0]   r_wcnt;
    logic [AW-1:0]   r_rcnt;
    logic            r_frame_err;

    logic            w_accept;
    logic            w_in_perm;
    logic            w_wdone;
    logic            w_pop;
    logic            w_rdone;
    logic [AW-1:0]   w_waddr;
    logic [AW-1:0]   w_widx;

    assign in_ready  = !r_full[r_wbank];
    assign w_accept  = in_valid && in_ready;
    assign w_in_perm = ({1'b0, r_wcnt} < c_N_EXT);
    assign w_wdone   = w_accept && (r_wcnt == c_LAST);
    assign w_widx    = w_in_perm ? w_waddr : r_wcnt;

    assign out_valid = r_full[r_rbank];
    assign w_pop     = out_valid && out_ready;
    assign w_rdone   = w_pop && (r_rcnt == c_LAST);

    // Permuted write address; the tail region bypasses it via r_wcnt.
    prime_addr_gen #(
        .N  (N),
        .P  (P),
        .AW (AW)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_wdone),
        .advance (w_accept && w_in_perm),
        .addr    (w_waddr)
    );

    // Bank write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wbank][w_widx] <= in_data;
        end
    end

    // Write-side counter and bank selection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wcnt  <= '0;
            r_wbank <= 1'b0;
        end else if (w_accept) begin
            if (w_wdone) begin
                r_wcnt  <= '0;
                r_wbank <= ~r_wbank;
            end else begin
                r_wcnt <= r_wcnt + 1'b1;
            end
        end
    end

    // Read-side counter and bank selection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rcnt  <= '0;
            r_rbank <= 1'b0;
        end else if (w_pop) begin
            if (w_rdone) begin
                r_rcnt  <= '0;
                r_rbank <= ~r_rbank;
            end else begin
                r_rcnt <= r_rcnt + 1'b1;
            end
        end
    end

    // Full flags: set and clear always target different banks, since a set
    // needs the bank empty and a clear needs it full.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 2'b00;
        end else begin
            if (w_wdone) begin
                r_full[r_wbank] <= 1'b1;
            end
            if (w_rdone) begin
                r_full[r_rbank] <= 1'b0;
            end
        end
    end

    // Framing check: in_last must coincide exactly with the final index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_accept && (in_last != (r_wcnt == c_LAST));
        end
    end

    assign in_frame_err = r_frame_err;
    assign out_data     = out_valid ? r_mem[r_rbank][r_rcnt] : '0;
    assign out_last     = out_valid && (r_rcnt == c_LAST);

endmodule
`default_nettype wire
